// File: rtl/test_fifo.sv
// rtl/test_fifo.sv - 16-bit write / 128-bit read width-converting FIFO
// Slots fill in arrival order; the read side only sees complete 8-slot groups.

module test_fifo #(
   parameter int DEPTH = 128
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic [15:0]            din,
   input  logic                   wr_en,
   input  logic                   rd_en,
   output logic [127:0]           dout,
   output logic                   empty,
   output logic                   full,
   output logic                   overflow,
   output logic                   underflow,
   output logic [$clog2(DEPTH):0] rd_count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int WPW = AW + 4;
   localparam logic [WPW-1:0] CAP_SLOTS = WPW'(DEPTH * 8);

   // Write pointer counts 16-bit slots, read pointer counts 128-bit words;
   // both carry one extra MSB so full and empty stay distinguishable.
   logic [WPW-1:0]   wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WPW-1:0]   occ;
   logic [7:0][15:0] mem [DEPTH];
   logic             wr_ok;
   logic             rd_ok;
   logic [2:0]       lane;

   assign occ      = wr_ptr - {rd_ptr, 3'b000};
   assign full     = (occ == CAP_SLOTS);
   assign rd_count = occ[WPW-1:3];
   assign empty    = (rd_count == '0);

   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;
   // First word of a group lands in the most significant lane.
   assign lane  = 3'd7 - wr_ptr[2:0];

   always_ff @(posedge clk) begin
      if (rst_n && !clr && wr_ok) begin
         mem[wr_ptr[WPW-2:3]][lane] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         dout      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
            dout   <= mem[rd_ptr[AW-1:0]];
         end
         overflow  <= wr_en & full;
         underflow <= rd_en & empty;
      end
   end

endmodule

// File: tb/tb_test_fifo.sv
// tb/tb_test_fifo.sv - scoreboard bench for test_fifo at DEPTH=2

module tb_test_fifo;

   localparam int DEPTH = 2;
   localparam int NSLOT = DEPTH * 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clr = 1'b0;
   logic [15:0]  din = '0;
   logic         wr_en = 1'b0;
   logic         rd_en = 1'b0;
   logic [127:0] dout;
   logic         empty;
   logic         full;
   logic         overflow;
   logic         underflow;
   logic [$clog2(DEPTH):0] rd_count;

   int checks = 0;
   int errors = 0;

   logic [15:0]  slots[$];
   logic [127:0] exp_q[$];
   logic [127:0] m_dout = '0;
   logic         m_ovf = 1'b0;
   logic         m_unf = 1'b0;

   always #5 clk = ~clk;

   test_fifo #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wr_en(wr_en), .rd_en(rd_en),
      .dout(dout), .empty(empty), .full(full), .overflow(overflow),
      .underflow(underflow), .rd_count(rd_count)
   );

   // Drive one cycle of stimulus and advance the reference model past the edge.
   task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c);
      bit           full_m;
      bit           empty_m;
      logic [127:0] word;
      wr_en = w; din = d; rd_en = r; clr = c;
      full_m  = (slots.size() == NSLOT);
      empty_m = (slots.size() < 8);
      @(posedge clk);
      if (c) begin
         slots.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         m_ovf = w && full_m;
         m_unf = r && empty_m;
         if (r && !empty_m) begin
            word = '0;
            for (int i = 0; i < 8; i++) word = {word[111:0], slots.pop_front()};
            m_dout = word;
            exp_q.push_back(word);
         end
         if (w && !full_m) slots.push_back(d);
      end
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (dout !== 128'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); end
      checks++; if (rd_count !== '0) begin errors++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_partial();
      logic [127:0] e;
      for (int i = 0; i < 7; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL partial_empty: got %b want 1", empty); end
      step(1'b0, 16'h0, 1'b1, 1'b0);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL partial_underflow: got %b want 1", underflow); end
      checks++; if (dout !== 128'h0) begin errors++; $display("FAIL partial_dout: got %h want 0", dout); end
      step(1'b0, 16'h0, 1'b0, 1'b0);
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL partial_underflow_pulse: got %b want 0", underflow); end
      // Read rejected even though the same edge completes the group.
      step(1'b1, 16'h0107, 1'b1, 1'b0);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL complete_underflow: got %b want 1", underflow); end
      checks++; if (rd_count !== 2'd1) begin errors++; $display("FAIL complete_rd_count: got %0d want 1", rd_count); end
      step(1'b0, 16'h0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++; if (dout !== e) begin errors++; $display("FAIL complete_dout: got %h want %h", dout, e); end
   endtask

   task automatic test_packing();
      logic [127:0] e;
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 16'(i), 1'b0, 1'b0);
         if (i == 7) begin
            checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pack_empty7: got %b want 1", empty); end
         end
      end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL pack_empty8: got %b want 0", empty); end
      checks++; if (rd_count !== 2'd1) begin errors++; $display("FAIL pack_rd_count: got %0d want 1", rd_count); end
      step(1'b0, 16'h0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++; if (dout !== e) begin errors++; $display("FAIL pack_dout_sb: got %h want %h", dout, e); end
      checks++; if (dout !== 128'h00010002000300040005000600070008) begin errors++; $display("FAIL pack_dout: got %h want 00010002000300040005000600070008", dout); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pack_empty_after: got %b want 1", empty); end
   endtask

   task automatic test_full();
      logic [127:0] e;
      for (int i = 0; i < 16; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full); end
      checks++; if (rd_count !== 2'd2) begin errors++; $display("FAIL full_rd_count: got %0d want 2", rd_count); end
      step(1'b1, 16'hdead, 1'b0, 1'b0);
      checks++; if (overflow !== m_ovf || overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b want 1", overflow); end
      step(1'b0, 16'h0, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_pulse: got %b want 0", overflow); end
      // Rejected write alongside an accepted read still flags overflow.
      step(1'b1, 16'hbeef, 1'b1, 1'b0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow_rd: got %b want 1", overflow); end
      e = exp_q.pop_front();
      checks++; if (dout !== e) begin errors++; $display("FAIL full_dout0: got %h want %h", dout, e); end
      step(1'b0, 16'h0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++; if (dout !== e) begin errors++; $display("FAIL full_dout1: got %h want %h", dout, e); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", empty); end
   endtask

   task automatic test_wrap();
      logic [127:0] e;
      for (int i = 0; i < 8; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0);
      for (int r = 1; r <= 5; r++) begin
         for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'h3000 + 16'(r * 16 + i), (i == 0), 1'b0);
            checks++; if (rd_count !== 2'(slots.size() / 8)) begin errors++; $display("FAIL wrap_rd_count r%0d i%0d: got %0d want %0d", r, i, rd_count, slots.size() / 8); end
            if (i == 0) begin
               e = exp_q.pop_front();
               checks++; if (dout !== e) begin errors++; $display("FAIL wrap_dout r%0d: got %h want %h", r, dout, e); end
            end
         end
      end
      step(1'b0, 16'h0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++; if (dout !== e) begin errors++; $display("FAIL wrap_dout_last: got %h want %h", dout, e); end
   endtask

   task automatic test_flush();
      logic [127:0] e;
      for (int i = 0; i < 12; i++) step(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b want 1", empty); end
      checks++; if (rd_count !== '0) begin errors++; $display("FAIL flush_rd_count: got %0d want 0", rd_count); end
      checks++; if (dout !== m_dout) begin errors++; $display("FAIL flush_dout_hold: got %h want %h", dout, m_dout); end
      step(1'b1, 16'h4444, 1'b1, 1'b1);
      checks++; if ({overflow, underflow, empty} !== 3'b001) begin errors++; $display("FAIL flush_priority: got %b want 001", {overflow, underflow, empty}); end
      for (int i = 0; i < 8; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++; if (dout !== e) begin errors++; $display("FAIL flush_new_dout: got %h want %h", dout, e); end
   endtask

   task automatic test_async_reset();
      logic [127:0] e;
      for (int i = 0; i < 8; i++) step(1'b1, 16'h6000 + 16'(i), 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 8; i++) step(1'b1, 16'h6100 + 16'(i), 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (dout !== 128'h0) begin errors++; $display("FAIL areset_dout: got %h want 0", dout); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL areset_empty: got %b want 1", empty); end
      checks++; if (rd_count !== '0) begin errors++; $display("FAIL areset_rd_count: got %0d want 0", rd_count); end
      slots.delete();
      exp_q.delete();
      m_dout = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++; if (dout !== e) begin errors++; $display("FAIL areset_resume: got %h want %h", dout, e); end
   endtask

   initial begin
      test_reset();
      test_partial();
      test_packing();
      test_full();
      test_wrap();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/test_fifo.md
TEST_FIFO -- requirements
Module: test_fifo

Interface
REQ-001 Parameter DEPTH, default 128, capacity in 128-bit read words (power of two, at least 2).
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge; the block has no other clock.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port clr  input  1  synchronous active-high flush.
REQ-005 Port din  input  16  write data.
REQ-006 Port wr_en  input  1  write request, one 16-bit word per cycle.
REQ-007 Port rd_en  input  1  read request, one 128-bit word per cycle.
REQ-008 Port dout  output  128  registered read data.
REQ-009 Port empty  output  1  no complete 128-bit word stored.
REQ-010 Port full  output  1  no free 16-bit slot.
REQ-011 Port overflow  output  1  one-cycle pulse: write rejected.
REQ-012 Port underflow  output  1  one-cycle pulse: read rejected.
REQ-013 Port rd_count  output  log2(DEPTH)+1  number of complete 128-bit words stored.

Function
REQ-014 Storage SHALL hold DEPTH*8 16-bit slots, written in arrival order, with the write pointer at 16-bit granularity and the read pointer at 128-bit granularity.
REQ-015 Packing SHALL map the first 16-bit word of each group of 8 to dout[127:112], the second to dout[111:96], and so on; the eighth maps to dout[15:0].
REQ-016 A write (wr_en=1, full=0) SHALL store din at the clock edge.
REQ-017 A write with full=1 SHALL be discarded, leave storage and pointers unchanged, and pulse overflow high for the next cycle only; this applies even if rd_en is accepted in the same cycle.
REQ-018 A read (rd_en=1, empty=0) SHALL load the oldest complete word into dout at that edge (standard mode, not first-word-fall-through), so data is valid the cycle after rd_en.
REQ-019 dout SHALL hold its value when no read is accepted.
REQ-020 A read with empty=1 SHALL leave dout and the pointers unchanged and pulse underflow high for the next cycle only; this applies even if the same cycle's write completes a word.
REQ-021 empty, full and rd_count SHALL be combinational functions of the registered pointers, reflecting the state after each edge.
REQ-022 empty SHALL be 1 when fewer than 8 16-bit slots are occupied.
REQ-023 full SHALL be 1 when all DEPTH*8 slots are occupied.
REQ-024 rd_count SHALL equal floor(occupied slots/8).
REQ-025 Simultaneous accepted read and write SHALL both take effect in the same cycle: occupancy +1-8.
REQ-026 Pointers SHALL wrap modulo capacity, with one extra MSB for full/empty disambiguation; occupancy arithmetic is modulo 2*capacity.
REQ-027 A partial group (1-7 stored words) SHALL remain invisible to the read side until its eighth word arrives.
REQ-028 clr=1 SHALL, at the edge, zero both pointers, discard any partial group, clear overflow and underflow, and leave dout unchanged.
REQ-029 clr SHALL take priority over any wr_en or rd_en in the same cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force dout=0, empty=1, full=0, overflow=0, underflow=0, rd_count=0 and both pointers to 0, without waiting for a clock edge.
REQ-031 Reset mid-operation SHALL discard all stored data.
REQ-032 Operation SHALL resume at the first rising edge after rst_n returns high.
REQ-033 Memory contents need not be cleared by reset.

Verification
REQ-034 Packing: write 0x0001..0x0008 on 8 consecutive cycles -> empty falls after the 8th edge, rd_count=1; then rd_en for one cycle -> next cycle dout=0x00010002000300040005000600070008, empty=1.
REQ-035 Partial group: write 7 words -> empty stays 1; rd_en -> underflow pulses for 1 cycle and dout stays 0.
REQ-036 Full/overflow (DEPTH=2): write 16 words -> full=1, rd_count=2; a 17th write -> overflow pulses for 1 cycle; two reads return only the first 16 words in order.
REQ-037 Wrap: with DEPTH=2, perform 5 rounds of write 8 / read 1 -> every read returns its own group intact; simultaneous read and write at the wrap boundary keep rd_count correct.
REQ-038 Flush: write 12 words, pulse clr -> empty=1, rd_count=0; then write 8 new words and read -> dout contains only the new words.
REQ-039 Asynchronous reset: assert rst_n low between clock edges while data is stored -> empty=1 and dout=0 before the next clock edge.
